// File: rtl/riscv_exc_controller_if.sv
// Request/ack handshake between the exception arbiter (master) and the core controller (slave).
interface riscv_exc_controller_if;
    logic       exc_req_o;
    logic       exc_ack_i;
    logic       exc_kill_i;
    logic       is_irq_o;
    logic [5:0] vec_idx_o;
    logic [5:0] cause_o;
    logic       save_cause_o;

    modport master (
        output exc_req_o, is_irq_o, vec_idx_o, cause_o, save_cause_o,
        input  exc_ack_i, exc_kill_i
    );

    modport slave (
        input  exc_req_o, is_irq_o, vec_idx_o, cause_o, save_cause_o,
        output exc_ack_i, exc_kill_i
    );
endinterface

// File: rtl/riscv_exc_controller.sv
// Exception/interrupt arbiter: fixed-priority pick, registered request, req/ack handshake, irq ack.
// Optional macro RISCV_IRQ_LATCH_EN makes pending interrupts sticky (edge-captured, cleared on ack).
module riscv_exc_controller #(
    parameter int unsigned NUM_IRQ = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_IRQ-1:0]       irq_i,
    input  logic                     irq_enable_i,
    input  logic                     illegal_insn_i,
    input  logic                     ecall_insn_i,
    input  logic                     lsu_err_i,
    riscv_exc_controller_if.master   ctrl,
    output logic                     irq_ack_o,
    output logic [4:0]               irq_id_o
);

    localparam int unsigned ID_W  = 5;
    localparam int unsigned VEC_W = 6;

    localparam logic [VEC_W-1:0] VEC_ILLEGAL   = 6'd32;
    localparam logic [VEC_W-1:0] VEC_ECALL     = 6'd33;
    localparam logic [VEC_W-1:0] VEC_LSU       = 6'd34;
    localparam logic [VEC_W-1:0] CAUSE_ILLEGAL = 6'h02;
    localparam logic [VEC_W-1:0] CAUSE_ECALL   = 6'h0B;
    localparam logic [VEC_W-1:0] CAUSE_LSU     = 6'h05;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_REQ      = 2'd1,
        S_IRQ_DONE = 2'd2
    } state_e;

    state_e               r_state;
    state_e               w_state_nxt;
    logic [NUM_IRQ-1:0]   r_irq_pend;
    logic [VEC_W-1:0]     r_vec_idx;
    logic [VEC_W-1:0]     r_cause;
    logic                 r_is_irq;

    logic [NUM_IRQ-1:0]   w_irq_cand;
    logic                 w_irq_valid;
    logic [ID_W-1:0]      w_irq_id;
    logic                 w_sync_valid;
    logic [VEC_W-1:0]     w_sync_vec;
    logic [VEC_W-1:0]     w_sync_cause;
    logic                 w_capture;
    logic [VEC_W-1:0]     w_cap_vec;
    logic [VEC_W-1:0]     w_cap_cause;
    logic                 w_cap_irq;
    logic                 w_in_req;

`ifdef RISCV_IRQ_LATCH_EN
    logic [NUM_IRQ-1:0]   r_irq_prev;
    logic [NUM_IRQ-1:0]   w_pend_clr;

    assign w_pend_clr = irq_ack_o ? (NUM_IRQ'(1) << r_irq_id_sel()) : '0;

    function automatic logic [ID_W-1:0] r_irq_id_sel();
        return r_vec_idx[ID_W-1:0];
    endfunction

    // Sticky pending: set on a rising edge, cleared only when that id is acknowledged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_irq_prev <= '0;
            r_irq_pend <= '0;
        end else begin
            r_irq_prev <= irq_i;
            r_irq_pend <= (r_irq_pend & ~w_pend_clr) | (irq_i & ~r_irq_prev);
        end
    end
`else
    // Level sampling: one register stage on the raw interrupt lines.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_irq_pend <= '0;
        end else begin
            r_irq_pend <= irq_i;
        end
    end
`endif

    // Lowest enabled pending index wins among interrupts.
    always_comb begin
        w_irq_cand  = r_irq_pend & {NUM_IRQ{irq_enable_i}};
        w_irq_valid = |w_irq_cand;
        w_irq_id    = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (w_irq_cand[i]) begin
                w_irq_id = ID_W'(i);
            end
        end
    end

    always_comb begin
        w_sync_valid = lsu_err_i | illegal_insn_i | ecall_insn_i;
        if (lsu_err_i) begin
            w_sync_vec   = VEC_LSU;
            w_sync_cause = CAUSE_LSU;
        end else if (illegal_insn_i) begin
            w_sync_vec   = VEC_ILLEGAL;
            w_sync_cause = CAUSE_ILLEGAL;
        end else begin
            w_sync_vec   = VEC_ECALL;
            w_sync_cause = CAUSE_ECALL;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and capture decision; ack beats kill, kill beats sync preemption of an irq.
    always_comb begin
        w_state_nxt = r_state;
        w_capture   = 1'b0;
        w_cap_vec   = w_sync_vec;
        w_cap_cause = w_sync_cause;
        w_cap_irq   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_sync_valid) begin
                    w_capture   = 1'b1;
                    w_state_nxt = S_REQ;
                end else if (w_irq_valid) begin
                    w_capture   = 1'b1;
                    w_cap_vec   = {1'b0, w_irq_id};
                    w_cap_cause = {1'b1, w_irq_id};
                    w_cap_irq   = 1'b1;
                    w_state_nxt = S_REQ;
                end
            end
            S_REQ: begin
                if (ctrl.exc_ack_i) begin
                    w_state_nxt = r_is_irq ? S_IRQ_DONE : S_IDLE;
                end else if (ctrl.exc_kill_i) begin
                    w_state_nxt = S_IDLE;
                end else if (r_is_irq && w_sync_valid) begin
                    w_capture = 1'b1;
                end else if (r_is_irq && !irq_enable_i) begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_IRQ_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vec_idx <= '0;
            r_cause   <= '0;
            r_is_irq  <= 1'b0;
        end else if (w_capture) begin
            r_vec_idx <= w_cap_vec;
            r_cause   <= w_cap_cause;
            r_is_irq  <= w_cap_irq;
        end
    end

    // Request payload is only presented while the request is outstanding.
    assign w_in_req           = (r_state == S_REQ);
    assign ctrl.exc_req_o     = w_in_req;
    assign ctrl.is_irq_o      = w_in_req & r_is_irq;
    assign ctrl.vec_idx_o     = w_in_req ? r_vec_idx : '0;
    assign ctrl.cause_o       = w_in_req ? r_cause : '0;
    assign ctrl.save_cause_o  = w_in_req & ctrl.exc_ack_i;
    assign irq_ack_o          = (r_state == S_IRQ_DONE);
    assign irq_id_o           = irq_ack_o ? r_vec_idx[ID_W-1:0] : '0;

endmodule

// File: tb/tb_riscv_exc_controller.sv
// Directed plus randomized checks of riscv_exc_controller against a transaction-level model.
module tb_riscv_exc_controller;

    localparam int unsigned NUM_IRQ = 32;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] irq;
    logic        ie, ill, ecall, lsu;
    logic        irq_ack;
    logic [4:0]  irq_id;

    int checks = 0;
    int errors = 0;

    riscv_exc_controller_if u_if ();

    riscv_exc_controller #(.NUM_IRQ(NUM_IRQ)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .irq_i          (irq),
        .irq_enable_i   (ie),
        .illegal_insn_i (ill),
        .ecall_insn_i   (ecall),
        .lsu_err_i      (lsu),
        .ctrl           (u_if),
        .irq_ack_o      (irq_ack),
        .irq_id_o       (irq_id)
    );

    always #5 clk = ~clk;

    // Model: an outstanding request (source vector) and a pending irq acknowledgement.
    logic [31:0] m_pend, m_prev;
    bit          m_valid, m_done;
    int          m_vec, m_done_id;

    function automatic int cause_of(input int v);
        if (v < 32) return 32 + v;
        if (v == 32) return 2;
        if (v == 33) return 11;
        return 5;
    endfunction

    function automatic int sync_src();
        if (lsu) return 34;
        if (ill) return 32;
        if (ecall) return 33;
        return -1;
    endfunction

    function automatic int irq_src();
        for (int k = 0; k < 32; k++)
            if (m_pend[k] && ie) return k;
        return -1;
    endfunction

    task automatic model_reset();
        m_pend = '0; m_prev = '0; m_valid = 0; m_done = 0; m_vec = 0; m_done_id = 0;
    endtask

    task automatic model_advance();
        logic [31:0] clr;
        int s, q;
        clr = m_done ? (32'd1 << m_done_id) : 32'd0;
        s = sync_src();
        q = irq_src();
        if (m_done) begin
            m_done = 0;
        end else if (!m_valid) begin
            if (s >= 0) begin m_valid = 1; m_vec = s; end
            else if (q >= 0) begin m_valid = 1; m_vec = q; end
        end else if (u_if.exc_ack_i) begin
            m_valid = 0;
            if (m_vec < 32) begin m_done = 1; m_done_id = m_vec; end
        end else if (u_if.exc_kill_i) begin
            m_valid = 0;
        end else if (m_vec < 32 && s >= 0) begin
            m_vec = s;
        end else if (m_vec < 32 && !ie) begin
            m_valid = 0;
        end
`ifdef RISCV_IRQ_LATCH_EN
        m_pend = (m_pend & ~clr) | (irq & ~m_prev);
        m_prev = irq;
`else
        m_pend = irq;
        clr = '0;
`endif
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".req"},   32'(u_if.exc_req_o),    32'(m_valid));
        chk({tag, ".isirq"}, 32'(u_if.is_irq_o),     32'(m_valid && m_vec < 32));
        chk({tag, ".vec"},   32'(u_if.vec_idx_o),    m_valid ? 32'(m_vec) : 32'd0);
        chk({tag, ".cause"}, 32'(u_if.cause_o),      m_valid ? 32'(cause_of(m_vec)) : 32'd0);
        chk({tag, ".save"},  32'(u_if.save_cause_o), 32'(m_valid && u_if.exc_ack_i));
        chk({tag, ".iack"},  32'(irq_ack),           32'(m_done));
        chk({tag, ".iid"},   32'(irq_id),            m_done ? 32'(m_done_id) : 32'd0);
    endtask

    task automatic set_in(input logic [31:0] irq_v, input logic ie_v, input logic ill_v,
                          input logic ecall_v, input logic lsu_v, input logic ack_v,
                          input logic kill_v);
        irq = irq_v; ie = ie_v; ill = ill_v; ecall = ecall_v; lsu = lsu_v;
        u_if.exc_ack_i = ack_v; u_if.exc_kill_i = kill_v;
    endtask

    task automatic cyc(input string tag);
        @(negedge clk);
        check_model(tag);
        model_advance();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        set_in(32'd0, 0, 0, 0, 0, 0, 0);
        model_reset();
        #1;
        chk("rst.req", 32'(u_if.exc_req_o), 0);
        chk("rst.vec", 32'(u_if.vec_idx_o), 0);
        chk("rst.iack", 32'(irq_ack), 0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        // Illegal instruction, acked after three request cycles.
        set_in(32'd0, 1, 1, 0, 0, 0, 0); cyc("ill0");
        set_in(32'd0, 1, 0, 0, 0, 0, 0); #1;
        chk("ill.req", 32'(u_if.exc_req_o), 1);
        chk("ill.vec", 32'(u_if.vec_idx_o), 32);
        chk("ill.cause", 32'(u_if.cause_o), 32'h02);
        chk("ill.nosave", 32'(u_if.save_cause_o), 0);
        cyc("ill1"); cyc("ill2");
        set_in(32'd0, 1, 0, 0, 0, 1, 0); #1;
        chk("ill.save", 32'(u_if.save_cause_o), 1);
        cyc("ill3");
        set_in(32'd0, 1, 0, 0, 0, 0, 0); #1;
        chk("ill.done", 32'(u_if.exc_req_o), 0);
        chk("ill.noiack", 32'(irq_ack), 0);
        cyc("ill4");

        // Interrupts 4 and 6: lowest id wins, ack pulse follows acceptance.
        set_in(32'h50, 1, 0, 0, 0, 0, 0); cyc("irq0");
        #1 chk("irq.lat", 32'(u_if.exc_req_o), 0);
        cyc("irq1");
        #1;
        chk("irq.req", 32'(u_if.exc_req_o), 1);
        chk("irq.vec", 32'(u_if.vec_idx_o), 4);
        chk("irq.cause", 32'(u_if.cause_o), 32'h24);
        cyc("irq2");
        set_in(32'h50, 1, 0, 0, 0, 1, 0); cyc("irq3");
        set_in(32'h0, 1, 0, 0, 0, 0, 0); #1;
        chk("irq.iack", 32'(irq_ack), 1);
        chk("irq.iid", 32'(irq_id), 4);
        cyc("irq4"); cyc("irq5"); cyc("irq6");

        // Captured irq 2 is preempted by lsu error and illegal together.
        set_in(32'h4, 1, 0, 0, 0, 0, 0); cyc("pre0"); cyc("pre1");
        set_in(32'h4, 1, 1, 0, 1, 0, 0); #1;
        chk("pre.vec2", 32'(u_if.vec_idx_o), 2);
        cyc("pre2");
        set_in(32'h4, 0, 0, 0, 0, 0, 0); #1;
        chk("pre.cause", 32'(u_if.cause_o), 32'h05);
        chk("pre.vec", 32'(u_if.vec_idx_o), 34);
        chk("pre.isirq", 32'(u_if.is_irq_o), 0);
        cyc("pre3");
        set_in(32'h0, 0, 0, 0, 0, 1, 0); cyc("pre4");
        set_in(32'h0, 0, 0, 0, 0, 0, 0); cyc("pre5"); cyc("pre6");

        // Kill without and with a same-cycle ack.
        set_in(32'h0, 0, 0, 1, 0, 0, 0); cyc("kil0");
        set_in(32'h0, 0, 0, 0, 0, 0, 1); #1;
        chk("kil.nosave", 32'(u_if.save_cause_o), 0);
        cyc("kil1");
        #1 chk("kil.idle", 32'(u_if.exc_req_o), 0);
        set_in(32'h0, 0, 0, 1, 0, 0, 0); cyc("kil2");
        set_in(32'h0, 0, 0, 0, 0, 1, 1); #1;
        chk("kil.acksave", 32'(u_if.save_cause_o), 1);
        cyc("kil3");
        set_in(32'h0, 0, 0, 0, 0, 0, 0); cyc("kil4");

        // Global IE gating and withdrawal.
        set_in(32'h100, 0, 0, 0, 0, 0, 0); cyc("ie0"); cyc("ie1"); cyc("ie2");
        #1 chk("ie.noreq", 32'(u_if.exc_req_o), 0);
        set_in(32'h100, 1, 0, 0, 0, 0, 0); cyc("ie3");
        #1 chk("ie.req", 32'(u_if.exc_req_o), 1);
        set_in(32'h100, 0, 0, 0, 0, 0, 0); cyc("ie4");
        #1 chk("ie.wdrawn", 32'(u_if.exc_req_o), 0);
        set_in(32'h0, 0, 0, 0, 0, 0, 0); cyc("ie5"); cyc("ie6");

        // One-cycle pulse on irq 7 while IE is low.
        set_in(32'h80, 0, 0, 0, 0, 0, 0); cyc("pul0");
        set_in(32'h0, 0, 0, 0, 0, 0, 0); cyc("pul1");
        set_in(32'h0, 1, 0, 0, 0, 0, 0); cyc("pul2");
        #1;
`ifdef RISCV_IRQ_LATCH_EN
        chk("pul.req", 32'(u_if.exc_req_o), 1);
        chk("pul.vec", 32'(u_if.vec_idx_o), 7);
`else
        chk("pul.noreq", 32'(u_if.exc_req_o), 0);
`endif
        set_in(32'h0, 1, 0, 0, 0, 1, 0); cyc("pul3");
        set_in(32'h0, 1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) cyc("pul4");

        // Asynchronous reset in the middle of a request.
        set_in(32'h0, 1, 0, 1, 0, 0, 0); cyc("rr0");
        set_in(32'h0, 1, 0, 0, 0, 0, 0);
        #1 chk("rr.pre", 32'(u_if.exc_req_o), 1);
        #1 rst_n = 1'b0;
        #1;
        model_reset();
        chk("rr.req", 32'(u_if.exc_req_o), 0);
        chk("rr.cause", 32'(u_if.cause_o), 0);
        chk("rr.isirq", 32'(u_if.is_irq_o), 0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        // Randomized traffic against the model.
        for (int n = 0; n < 1500; n++) begin
            set_in($urandom() & $urandom() & $urandom(),
                   ($urandom_range(0, 7) != 0),
                   ($urandom_range(0, 15) == 0),
                   ($urandom_range(0, 15) == 0),
                   ($urandom_range(0, 23) == 0),
                   ($urandom_range(0, 3) == 0),
                   ($urandom_range(0, 15) == 0));
            cyc("rnd");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
